// File: rtl/busy_arbiter_if.sv
// Request/grant bundle between the requesters, the shared resource and
// busy_arbiter.
//
// Handshake: a requester raises req[i] and holds it until gnt[i] rises.
// gnt[i] then stays high for the whole operation, and start pulses in the
// first grant cycle. The resource answers on res_busy, which is a plain level.
// The operation ends with a one-cycle done[i], plus timeout_err when res_busy
// never rose.
interface busy_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0] req;
  logic            res_busy;
  logic [NREQ-1:0] gnt;
  logic            start;
  logic [NREQ-1:0] done;
  logic            timeout_err;
  logic            arb_busy;

  // Requesters and the resource side.
  modport master (
    output req,
    output res_busy,
    input  gnt,
    input  start,
    input  done,
    input  timeout_err,
    input  arb_busy
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  res_busy,
    output gnt,
    output start,
    output done,
    output timeout_err,
    output arb_busy
  );
endinterface

// File: rtl/busy_arbiter.sv
// Round-robin arbiter that serialises access to one busy-signalling resource.
// It grants one requester, pulses start, follows res_busy until the resource
// finishes or the start times out, and pulses done to the owner. It then
// waits a guard gap before it arbitrates again.
module busy_arbiter #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 8,
  parameter int GUARD_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  busy_arbiter_if.slave        io_bus,
  output logic [1:0]           o_state
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (START_TIMEOUT > GUARD_CYCLES) ? START_TIMEOUT : GUARD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  // Value the counter holds on the last low sample and on the last guard cycle.
  localparam logic [CW-1:0] TO_LAST    = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? CW'(GUARD_CYCLES - 1) : '0;
  localparam logic [PW-1:0] PTR_RST    = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_BUSY      = 2'd2,
    S_GUARD     = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic            r_start, w_start_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic            r_timeout_err, w_timeout_err_nxt;
  logic            w_end_op;
  logic [PW-1:0]   w_win;
  logic [NREQ-1:0] w_win_onehot;

  // Return the first set request above ptr, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [PW-1:0]   ptr);
    logic [PW-1:0] win;
    logic          found;
    int            idx;
    win   = ptr;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    return win;
  endfunction

  // Round-robin winner among the current requests.
  always_comb begin
    w_win        = rr_pick(io_bus.req, r_ptr);
    w_win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
  end

  // Next state and next register values. Every field defaults to "hold",
  // and the pulses default to low.
  always_comb begin
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_cnt_nxt         = r_cnt;
    w_gnt_nxt         = r_gnt;
    w_start_nxt       = 1'b0;
    w_done_nxt        = '0;
    w_timeout_err_nxt = 1'b0;
    w_end_op          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|io_bus.req) begin
          w_state_nxt = S_WAIT_BUSY;
          w_gnt_nxt   = w_win_onehot;
          w_start_nxt = 1'b1;
          w_ptr_nxt   = w_win;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_BUSY: begin
        // The resource cannot react inside the start cycle, so res_busy is
        // only sampled from the cycle after start.
        if (!r_start) begin
          if (io_bus.res_busy) begin
            w_state_nxt = S_BUSY;
          end else if (r_cnt == TO_LAST) begin
            w_end_op          = 1'b1;
            w_timeout_err_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_BUSY: begin
        if (!io_bus.res_busy) begin
          w_end_op = 1'b1;
        end
      end
      S_GUARD: begin
        // The done cycle is the first guard cycle.
        if (r_cnt == GUARD_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Common end of an operation: release the grant and tell the owner.
    if (w_end_op) begin
      w_done_nxt  = r_gnt;
      w_gnt_nxt   = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
    end
  end

  // State and output registers. An asynchronous reset aborts any operation
  // in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= PTR_RST;
      r_cnt         <= '0;
      r_gnt         <= '0;
      r_start       <= 1'b0;
      r_done        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_gnt         <= w_gnt_nxt;
      r_start       <= w_start_nxt;
      r_done        <= w_done_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign io_bus.gnt         = r_gnt;
  assign io_bus.start       = r_start;
  assign io_bus.done        = r_done;
  assign io_bus.timeout_err = r_timeout_err;
  assign io_bus.arb_busy    = (r_state != S_IDLE);
  assign o_state            = r_state;

endmodule

// File: doc/busy_arbiter.md
# busy_arbiter

Round-robin arbiter that shares one busy-signalling resource among NREQ requesters. It issues a one-cycle start to the resource and holds the one-hot grant while the resource's busy level is high. On completion or start-timeout it pulses done to the owner, then enforces a guard gap before the next grant. It sits in front of any shared engine whose busy output is level-valid, including extended busy.

## Interface
- NREQ, 4, number of requesters; legal range ≥ 2
- START_TIMEOUT, 8, cycles after start within which res_busy must rise; legal range ≥ 1
- GUARD_CYCLES, 4, idle gap after each operation before re-arbitration; legal range ≥ 0
- clk  in  1  clock, all logic on posedge
- reset  in  1  reset, asynchronous, active-high
- req  in  NREQ  level request per requester; must be held until granted
- res_busy  in  1  resource busy level
- gnt  out  NREQ  one-hot grant, held for the whole operation
- start  out  1  one-cycle pulse to the resource, coincident with the first gnt cycle
- done  out  NREQ  one-cycle pulse to the owner at operation end
- timeout_err  out  1  one-cycle pulse, coincident with done, when res_busy never rose
- arb_busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, WAIT_BUSY, BUSY, GUARD. Reset → IDLE.
- Reset values: gnt=0, start=0, done=0, timeout_err=0, arb_busy=0, rr pointer=NREQ-1, counters=0.
- Reset asserted mid-operation clears everything immediately (async). No done is issued for the aborted owner.
- IDLE → WAIT_BUSY:
  - Taken when |req=1.
  - The winner is the first set req bit searching from pointer+1 upward, wrapping modulo NREQ.
  - At the same edge: gnt=onehot(winner), start=1, pointer=winner, cnt=0.
- WAIT_BUSY:
  - res_busy is ignored in the start cycle. Sampling begins the following cycle.
  - Sampled res_busy=1 → BUSY.
  - After START_TIMEOUT consecutive low samples → end operation with timeout_err=1.
- BUSY: sampled res_busy=0 → end operation.
- End operation, all at one edge:
  - done[owner]=1 for one cycle, gnt=0.
  - timeout_err=1 for one cycle, only when the end came from a timeout.
  - Next state is GUARD with cnt=0, or IDLE if GUARD_CYCLES=0.
- GUARD:
  - Lasts exactly GUARD_CYCLES cycles, with the done cycle counted as the first.
  - Then → IDLE. req and res_busy are ignored.
- Grant is never revoked early. The owner dropping req mid-operation has no effect.
- req is not latched: a requester that drops req before being sampled in IDLE is not served.
- res_busy glitches during IDLE/GUARD have no effect.
- Counters are $clog2(max(START_TIMEOUT, GUARD_CYCLES)+1) bits wide and never wrap.
- Invariants: gnt is one-hot or zero; done is one-hot or zero; start implies gnt≠0.

## Timing
- Arbitration latency: req sampled high in IDLE at cycle T → gnt and start high in cycle T+1.
- Completion: res_busy first sampled low in BUSY at cycle B → done high in B+1 and gnt low from B+1.
- Timeout: start in cycle T+1; samples taken in T+2 … T+1+START_TIMEOUT all low → done and timeout_err high in T+2+START_TIMEOUT.
- Re-arbitration: done in cycle D → IDLE in D+GUARD_CYCLES → next gnt no earlier than D+GUARD_CYCLES+1.
  - With GUARD_CYCLES=0, IDLE is D itself and the next gnt is at D+1.
- Minimum operation (res_busy high one sampled cycle): start T+1, busy T+2, low T+3, done T+4.

## Test plan
- Single request: req=4'b0100 at T → gnt=0100 and start in T+1. Busy high T+3..T+6 → done=0100 in T+8, timeout_err=0, arb_busy low from T+12 (GUARD_CYCLES=4).
- Round robin: req=4'b1111 held continuously, each operation 3 busy cycles → grant order 0,1,2,3,0. Each start is spaced by operation length + 4 guard + 1 idle cycles.
- Timeout: req=0001, res_busy held 0 → done=0001 and timeout_err=1 exactly 9 cycles after the start cycle, then normal guard.
- Guard/glitch: res_busy pulses during GUARD and a new req arrives in GUARD → no grant until IDLE, grant one cycle later. Repeat with GUARD_CYCLES=0 → back-to-back grant at done+1.
- Owner drop and stale request: owner drops req mid-BUSY → gnt held until done. A requester that pulses req only during BUSY → never granted.
- Async reset during BUSY → all outputs 0 immediately, no done. After release, req=1000 → gnt=1000 (pointer reset, search starts at bit 0, only bit 3 set).
